// File: rtl/countm_param.sv
// Runtime-modulus up/down counter with load, enable and combinational terminal count.
// Optional wrap-event counter output is enabled by defining COUNTM_WRAPCNT_EN.
module countm_param #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  m,
  output logic [WIDTH-1:0]  q,
  output logic              tc
`ifdef COUNTM_WRAPCNT_EN
  ,
  output logic [CWIDTH-1:0] wrap_cnt
`endif
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic             m_small_s;
  logic [WIDTH-1:0] m_minus1_s;
  logic             at_term_s;
  logic             in_range_s;
  logic             tc_s;

  // Decode modulus and terminal-count condition for the current state.
  always_comb begin
    m_small_s  = (m <= WIDTH'(1));
    m_minus1_s = m - WIDTH'(1);
    in_range_s = (q_q < m);
    if (up) begin
      at_term_s = (q_q == m_minus1_s);
    end else begin
      at_term_s = (q_q == {WIDTH{1'b0}});
    end
    tc_s = en & ~load & (m_small_s | (in_range_s & at_term_s));
  end

  // Next-state count; out-of-range q (m lowered at runtime) snaps to the wrap target.
  always_comb begin
    q_d = q_q;
    if (m_small_s) begin
      q_d = {WIDTH{1'b0}};
    end else if (load) begin
      if (load_val < m) begin
        q_d = load_val;
      end else begin
        q_d = {WIDTH{1'b0}};
      end
    end else if (en) begin
      if (up) begin
        if (q_q >= m_minus1_s) begin
          q_d = {WIDTH{1'b0}};
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if ((q_q == {WIDTH{1'b0}}) || (q_q >= m)) begin
          q_d = m_minus1_s;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end else begin
      q_d = q_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = tc_s;

`ifdef COUNTM_WRAPCNT_EN
  logic [CWIDTH-1:0] wrap_cnt_d;
  logic [CWIDTH-1:0] wrap_cnt_q;

  // Wrap events accumulate modulo 2^CWIDTH.
  always_comb begin
    if (tc_s) begin
      wrap_cnt_d = wrap_cnt_q + CWIDTH'(1);
    end else begin
      wrap_cnt_d = wrap_cnt_q;
    end
  end

  // Wrap counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_cnt_q <= {CWIDTH{1'b0}};
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_countm_param.sv
// Self-checking bench for countm_param: vector table with a q scoreboard,
// plus hand-written reset and two-stage cascade sequences.
module tb_countm_param;

  logic        clk;
  logic        rst;
  logic        en;
  logic        up;
  logic        load;
  logic [7:0]  load_val;
  logic [7:0]  m;
  logic [7:0]  q;
  logic        tc;

  logic        c_en0;
  logic [7:0]  c_m;
  logic [7:0]  c_q0;
  logic [7:0]  c_q1;
  logic        c_tc0;
  logic        c_tc1;

`ifdef COUNTM_WRAPCNT_EN
  logic [15:0] wrap_cnt;
  logic [15:0] c_wc0;
  logic [15:0] c_wc1;
`endif

  int tests = 0;
  int fails = 0;
  int wrap_exp = 0;
  logic [7:0] q_sb[$];

  typedef struct {
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] lv;
    logic [7:0] m;
    logic       tc;
    logic [7:0] q;
    string      name;
  } vec_t;
  vec_t vecs[$];

  countm_param #(.WIDTH(8), .CWIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .m(m), .q(q), .tc(tc)
`ifdef COUNTM_WRAPCNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  countm_param #(.WIDTH(8), .CWIDTH(16)) u_s0 (
    .clk(clk), .rst(rst), .en(c_en0), .up(1'b1), .load(1'b0),
    .load_val(8'd0), .m(c_m), .q(c_q0), .tc(c_tc0)
`ifdef COUNTM_WRAPCNT_EN
    , .wrap_cnt(c_wc0)
`endif
  );

  countm_param #(.WIDTH(8), .CWIDTH(16)) u_s1 (
    .clk(clk), .rst(rst), .en(c_tc0), .up(1'b1), .load(1'b0),
    .load_val(8'd0), .m(c_m), .q(c_q1), .tc(c_tc1)
`ifdef COUNTM_WRAPCNT_EN
    , .wrap_cnt(c_wc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic u, input logic l, input logic [7:0] lv,
                     input logic [7:0] mm, input logic etc, input logic [7:0] eq, input string nm);
    vec_t v;
    v.en = e; v.up = u; v.load = l; v.lv = lv; v.m = mm; v.tc = etc; v.q = eq; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs, check tc combinationally, then check q after the edge.
  task automatic step(input vec_t v);
    logic [7:0] exp_q;
    en = v.en; up = v.up; load = v.load; load_val = v.lv; m = v.m;
    #1;
    chk({v.name, "_tc"}, 32'(tc), 32'(v.tc));
    q_sb.push_back(v.q);
    if (v.tc) wrap_exp++;
    @(posedge clk);
    #1;
    exp_q = q_sb.pop_front();
    chk({v.name, "_q"}, 32'(q), 32'(exp_q));
`ifdef COUNTM_WRAPCNT_EN
    chk({v.name, "_wrap"}, 32'(wrap_cnt), 32'(wrap_exp));
`endif
  endtask

  initial begin
    int tc1_cnt;
    vec_t v;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'd0; m = 8'd10;
    c_en0 = 1'b0; c_m = 8'd10;

    // up count m=10 from 0: 12 edges
    for (int i = 0; i < 12; i++)
      add(1'b1, 1'b1, 1'b0, 8'd0, 8'd10, (i % 10) == 9, 8'((i + 1) % 10), $sformatf("up%0d", i));
    add(1'b1, 1'b1, 1'b1, 8'd0,  8'd10, 1'b0, 8'd0,  "ld0");
    add(1'b1, 1'b0, 1'b0, 8'd0,  8'd10, 1'b1, 8'd9,  "dn_wrap");
    add(1'b1, 1'b0, 1'b0, 8'd0,  8'd10, 1'b0, 8'd8,  "dn8");
    add(1'b1, 1'b0, 1'b0, 8'd0,  8'd10, 1'b0, 8'd7,  "dn7");
    add(1'b1, 1'b1, 1'b1, 8'd8,  8'd10, 1'b0, 8'd8,  "ld8a");
    add(1'b1, 1'b1, 1'b0, 8'd0,  8'd5,  1'b0, 8'd0,  "mlow_up");
    add(1'b1, 1'b1, 1'b1, 8'd8,  8'd10, 1'b0, 8'd8,  "ld8b");
    add(1'b1, 1'b0, 1'b0, 8'd0,  8'd5,  1'b0, 8'd4,  "mlow_dn");
    add(1'b1, 1'b1, 1'b1, 8'd3,  8'd10, 1'b0, 8'd3,  "ld3");
    add(1'b1, 1'b1, 1'b1, 8'd12, 8'd10, 1'b0, 8'd0,  "ld12");
    add(1'b0, 1'b1, 1'b0, 8'd0,  8'd10, 1'b0, 8'd0,  "hold0");
    add(1'b0, 1'b1, 1'b1, 8'd9,  8'd10, 1'b0, 8'd9,  "ld9_noen");
    add(1'b0, 1'b1, 1'b0, 8'd0,  8'd10, 1'b0, 8'd9,  "hold9");
    add(1'b1, 1'b1, 1'b1, 8'd2,  8'd10, 1'b0, 8'd2,  "ld_over_tc");
    add(1'b1, 1'b1, 1'b0, 8'd0,  8'd1,  1'b1, 8'd0,  "m1_a");
    add(1'b1, 1'b1, 1'b0, 8'd0,  8'd1,  1'b1, 8'd0,  "m1_b");
    add(1'b1, 1'b0, 1'b0, 8'd0,  8'd1,  1'b1, 8'd0,  "m1_c");
    add(1'b0, 1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 8'd0,  "m0_noen");
    add(1'b1, 1'b1, 1'b1, 8'd7,  8'd0,  1'b0, 8'd0,  "m0_load");
    add(1'b1, 1'b1, 1'b1, 8'd254, 8'd255, 1'b0, 8'd254, "ld254");
    add(1'b1, 1'b1, 1'b0, 8'd0,  8'd255, 1'b1, 8'd0,  "m255_wrap");
    add(1'b1, 1'b1, 1'b1, 8'd5,  8'd10, 1'b0, 8'd5,  "ld5");

    #3;
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_tc", 32'(tc), 32'd0);
`ifdef COUNTM_WRAPCNT_EN
    chk("reset_wrap", 32'(wrap_cnt), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // asynchronous reset mid-count from q=5
    en = 1'b1; up = 1'b1; load = 1'b0; m = 8'd10;
    #2;
    rst = 1'b1;
    wrap_exp = 0;
    #1;
    chk("async_rst_q", 32'(q), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_held_q", 32'(q), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    v.en = 1'b1; v.up = 1'b1; v.load = 1'b0; v.lv = 8'd0; v.m = 8'd10;
    v.tc = 1'b0; v.q = 8'd1; v.name = "post_rst";
    step(v);

    // two-stage cascade, 100 enabled edges
    @(negedge clk);
    c_en0 = 1'b1;
    tc1_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 45) begin
        chk("casc_q0_45", 32'(c_q0), 32'd5);
        chk("casc_q1_45", 32'(c_q1), 32'd4);
      end
      if (c_tc1) tc1_cnt++;
      @(posedge clk);
      #1;
    end
    c_en0 = 1'b0;
    #1;
    chk("casc_q0_end", 32'(c_q0), 32'd0);
    chk("casc_q1_end", 32'(c_q1), 32'd0);
    chk("casc_tc1_cnt", 32'(tc1_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
